// File: rtl/v_tile_if.sv
//------------------------------------------------------------------------------
// Module  : v_tile_if
// Brief   : Handshake/bus bundle for the v_tile vector ALU tile: three write
//           ports (two operand vectors and one config word), the start
//           request and the result/tag/ack outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface v_tile_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4
);
  logic                          on_off;

  logic                          write_en1;
  logic                          write_rdy1;
  logic [WIDTH*NUM_INPUTS-1:0]   w_data_in1;
  logic                          write_ack1;

  logic                          write_en2;
  logic                          write_rdy2;
  logic [WIDTH*NUM_INPUTS-1:0]   w_data_in2;
  logic                          write_ack2;

  logic                          write_en3;
  logic                          write_rdy3;
  logic [WIDTH-1:0]              w_data_in3;
  logic                          write_ack3;

  logic [WIDTH*NUM_INPUTS-1:0]   adder_outputs;
  logic [3:0]                    dest_info;
  logic                          adder_ack;

  // Upstream producer / controller side
  modport master (
    output on_off,
    output write_en1, w_data_in1, input write_rdy1, write_ack1,
    output write_en2, w_data_in2, input write_rdy2, write_ack2,
    output write_en3, w_data_in3, input write_rdy3, write_ack3,
    input  adder_outputs, dest_info, adder_ack
  );

  // Tile side
  modport slave (
    input  on_off,
    input  write_en1, w_data_in1, output write_rdy1, write_ack1,
    input  write_en2, w_data_in2, output write_rdy2, write_ack2,
    input  write_en3, w_data_in3, output write_rdy3, write_ack3,
    output adder_outputs, dest_info, adder_ack
  );
endinterface

`default_nettype wire

// File: rtl/v_tile.sv
//------------------------------------------------------------------------------
// Module  : v_tile
// Brief   : CGRA vector ALU tile. Loads two operand vectors and a config word
//           through independent ready/enable/ack handshakes, then on on_off
//           computes add / pairwise-reduce / subtract / AND and presents the
//           result with adder_ack and a 4-bit routing tag.
//           Optional build macro: VTILE_SAT_ARITH_EN (saturating add/reduce,
//           clamp-to-zero subtract). Default build wraps modulo 2^WIDTH.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module v_tile #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,   // even, >= 2
  parameter int NUM_REGS   = 16   // >= 2*NUM_INPUTS+1
) (
  input  logic     clk,
  input  logic     reset,
  v_tile_if.slave  bus
);

  localparam int VW = WIDTH * NUM_INPUTS;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              loaded1_q, loaded1_d;
  logic              loaded2_q, loaded2_d;
  logic              loaded3_q, loaded3_d;
  logic              ack1_q, ack1_d;
  logic              ack2_q, ack2_d;
  logic              ack3_q, ack3_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  regs_d [NUM_REGS];
  logic [VW-1:0]     out_q, out_d;
  logic [3:0]        dest_q, dest_d;
  logic              adder_ack_q, adder_ack_d;

  logic              w_rdy1, w_rdy2, w_rdy3;
  logic              w_take1, w_take2, w_take3;
  logic [1:0]        w_opcode;
  logic [3:0]        w_dest;
  logic [VW-1:0]     w_alu;

  // Slots accept only while loading and empty; held low throughout reset.
  assign w_rdy1  = (state_q == S_LOAD) && !loaded1_q && !reset;
  assign w_rdy2  = (state_q == S_LOAD) && !loaded2_q && !reset;
  assign w_rdy3  = (state_q == S_LOAD) && !loaded3_q && !reset;
  assign w_take1 = bus.write_en1 && w_rdy1;
  assign w_take2 = bus.write_en2 && w_rdy2;
  assign w_take3 = bus.write_en3 && w_rdy3;

  assign w_opcode = regs_q[NUM_REGS-1][1:0];
  assign w_dest   = regs_q[NUM_REGS-1][11:8];

  // One lane per output word. For both halves of the pairwise reduce the
  // source pair sits at regs[2k], regs[2k+1]: vector 2 starts at regs[n], so
  // its pair (2(k-n/2), +1) lands on the same flat indices.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
    logic [WIDTH-1:0] w_a, w_b, w_pa, w_pb;
    logic [WIDTH-1:0] w_add, w_red, w_sub, w_res;

    assign w_a  = regs_q[k];
    assign w_b  = regs_q[NUM_INPUTS + k];
    assign w_pa = regs_q[2*k];
    assign w_pb = regs_q[2*k + 1];

`ifdef VTILE_SAT_ARITH_EN
    logic [WIDTH:0] w_sum, w_psum, w_dif;
    assign w_sum  = {1'b0, w_a}  + {1'b0, w_b};
    assign w_psum = {1'b0, w_pa} + {1'b0, w_pb};
    assign w_dif  = {1'b0, w_a}  - {1'b0, w_b};
    assign w_add  = w_sum[WIDTH]  ? '1 : w_sum[WIDTH-1:0];
    assign w_red  = w_psum[WIDTH] ? '1 : w_psum[WIDTH-1:0];
    assign w_sub  = w_dif[WIDTH]  ? '0 : w_dif[WIDTH-1:0];
`else
    assign w_add  = w_a  + w_b;
    assign w_red  = w_pa + w_pb;
    assign w_sub  = w_a  - w_b;
`endif

    // Select this lane's result by opcode.
    always_comb begin
      w_res = '0;
      case (w_opcode)
        2'b00:   w_res = w_add;
        2'b01:   w_res = w_red;
        2'b10:   w_res = w_sub;
        default: w_res = w_a & w_b;
      endcase
    end

    assign w_alu[k*WIDTH +: WIDTH] = w_res;
  end

  // Next-state: slot capture, LOAD/EXEC/DONE sequencing, result registration.
  always_comb begin
    state_d     = state_q;
    loaded1_d   = loaded1_q;
    loaded2_d   = loaded2_q;
    loaded3_d   = loaded3_q;
    ack1_d      = w_take1;
    ack2_d      = w_take2;
    ack3_d      = w_take3;
    regs_d      = regs_q;
    out_d       = out_q;
    dest_d      = dest_q;
    adder_ack_d = adder_ack_q;

    if (w_take1) begin
      loaded1_d = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) regs_d[i] = bus.w_data_in1[i*WIDTH +: WIDTH];
    end
    if (w_take2) begin
      loaded2_d = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) regs_d[NUM_INPUTS+i] = bus.w_data_in2[i*WIDTH +: WIDTH];
    end
    if (w_take3) begin
      loaded3_d = 1'b1;
      regs_d[NUM_REGS-1] = bus.w_data_in3;
    end

    case (state_q)
      S_LOAD: begin
        if (bus.on_off && loaded1_q && loaded2_q && loaded3_q) state_d = S_EXEC;
      end
      S_EXEC: begin
        // Result is committed even if on_off has already dropped.
        state_d     = S_DONE;
        out_d       = w_alu;
        dest_d      = w_dest;
        adder_ack_d = 1'b1;
      end
      S_DONE: begin
        if (!bus.on_off) begin
          state_d     = S_LOAD;
          adder_ack_d = 1'b0;
          loaded1_d   = 1'b0;
          loaded2_d   = 1'b0;
          loaded3_d   = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State registers with synchronous reset clearing all work in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      loaded1_q   <= 1'b0;
      loaded2_q   <= 1'b0;
      loaded3_q   <= 1'b0;
      ack1_q      <= 1'b0;
      ack2_q      <= 1'b0;
      ack3_q      <= 1'b0;
      regs_q      <= '{default: '0};
      out_q       <= '0;
      dest_q      <= '0;
      adder_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      loaded1_q   <= loaded1_d;
      loaded2_q   <= loaded2_d;
      loaded3_q   <= loaded3_d;
      ack1_q      <= ack1_d;
      ack2_q      <= ack2_d;
      ack3_q      <= ack3_d;
      regs_q      <= regs_d;
      out_q       <= out_d;
      dest_q      <= dest_d;
      adder_ack_q <= adder_ack_d;
    end
  end

  assign bus.write_rdy1    = w_rdy1;
  assign bus.write_rdy2    = w_rdy2;
  assign bus.write_rdy3    = w_rdy3;
  assign bus.write_ack1    = ack1_q;
  assign bus.write_ack2    = ack2_q;
  assign bus.write_ack3    = ack3_q;
  assign bus.adder_outputs = out_q;
  assign bus.dest_info     = dest_q;
  assign bus.adder_ack     = adder_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_v_tile.sv
//------------------------------------------------------------------------------
// Module  : tb_v_tile
// Brief   : Self-checking bench for v_tile: directed scenarios plus randomized
//           operations compared against an arithmetic reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_v_tile;

  localparam int     W    = 16;
  localparam int     N    = 4;
  localparam int     R    = 16;
  localparam longint MAXV = (64'd1 << W) - 1;

  typedef int unsigned vec_t [N];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  v_tile_if #(.WIDTH(W), .NUM_INPUTS(N)) bus ();

  v_tile #(.WIDTH(W), .NUM_INPUTS(N), .NUM_REGS(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack(input vec_t v);
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = v[k][W-1:0];
    return r;
  endfunction

  // Reference: operation semantics straight from the opcode definitions.
  function automatic logic [N*W-1:0] ref_result(input int unsigned op, input vec_t a, input vec_t b);
    logic [N*W-1:0] res;
    longint x, y, r;
    res = '0;
    for (int k = 0; k < N; k++) begin
      if (op == 1) begin
        if (k < N/2) begin x = a[2*k]; y = a[2*k+1]; end
        else begin x = b[2*(k-N/2)]; y = b[2*(k-N/2)+1]; end
      end else begin
        x = a[k]; y = b[k];
      end
      case (op)
`ifdef VTILE_SAT_ARITH_EN
        0, 1:    r = (x + y > MAXV) ? MAXV : x + y;
        2:       r = (x < y) ? 0 : x - y;
`else
        0, 1:    r = (x + y) % (MAXV + 1);
        2:       r = (x - y + MAXV + 1) % (MAXV + 1);
`endif
        default: r = x & y;
      endcase
      res[k*W +: W] = r[W-1:0];
    end
    return res;
  endfunction

  function automatic int unsigned rand_word();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 32'(MAXV);
      default: return $urandom_range(0, 32'(MAXV));
    endcase
  endfunction

  task automatic idle_inputs();
    bus.on_off    = 1'b0;
    bus.write_en1 = 1'b0;
    bus.write_en2 = 1'b0;
    bus.write_en3 = 1'b0;
  endtask

  task automatic load_parallel(input logic [W-1:0] cfg, input vec_t a, input vec_t b);
    bus.w_data_in1 = pack(a);
    bus.w_data_in2 = pack(b);
    bus.w_data_in3 = cfg;
    bus.write_en1 = 1'b1; bus.write_en2 = 1'b1; bus.write_en3 = 1'b1;
    tick();
    check_eq("par_acks", {bus.write_ack1, bus.write_ack2, bus.write_ack3}, 3'b111);
    bus.write_en1 = 1'b0; bus.write_en2 = 1'b0; bus.write_en3 = 1'b0;
  endtask

  // Each port starts after its own random delay; returns just after the
  // edge that accepted the last slot.
  task automatic load_random(input logic [W-1:0] cfg, input vec_t a, input vec_t b, input bit early);
    int dly [3];
    bit pend [3];
    int guard;
    guard = 0;
    bus.w_data_in1 = pack(a);
    bus.w_data_in2 = pack(b);
    bus.w_data_in3 = cfg;
    for (int p = 0; p < 3; p++) begin dly[p] = $urandom_range(0, 3); pend[p] = 1'b1; end
    if (early) bus.on_off = 1'b1;
    while ((pend[0] || pend[1] || pend[2]) && guard < 40) begin
      bus.write_en1 = pend[0] && (dly[0] == 0);
      bus.write_en2 = pend[1] && (dly[1] == 0);
      bus.write_en3 = pend[2] && (dly[2] == 0);
      tick();
      guard++;
      if (bus.write_ack1) pend[0] = 1'b0;
      if (bus.write_ack2) pend[1] = 1'b0;
      if (bus.write_ack3) pend[2] = 1'b0;
      for (int p = 0; p < 3; p++) if (dly[p] > 0) dly[p]--;
    end
    bus.write_en1 = 1'b0; bus.write_en2 = 1'b0; bus.write_en3 = 1'b0;
    check_eq("load_done", {pend[0], pend[1], pend[2]}, 3'b000);
    check_eq("load_noack", bus.adder_ack, 1'b0);
  endtask

  // Start, check latency/result/tag, optionally hold, then release.
  // drop_exec=1 releases on_off while the tile is in EXEC.
  task automatic finish_op(input logic [W-1:0] cfg, input vec_t a, input vec_t b, input bit drop_exec);
    logic [N*W-1:0] exp;
    int hold;
    exp = ref_result(cfg & 16'h3, a, b);
    bus.on_off = 1'b1;
    tick();
    check_eq("lat1_ack", bus.adder_ack, 1'b0);
    if (drop_exec) bus.on_off = 1'b0;
    tick();
    check_eq("lat2_ack", bus.adder_ack, 1'b1);
    check_eq("result", bus.adder_outputs, exp);
    check_eq("dest", bus.dest_info, (cfg >> 8) & 16'hF);
    if (!drop_exec) begin
      hold = $urandom_range(0, 3);
      repeat (hold) tick();
      check_eq("hold_ack", bus.adder_ack, 1'b1);
      check_eq("hold_out", bus.adder_outputs, exp);
      bus.on_off = 1'b0;
    end
    tick();
    check_eq("drop_ack", bus.adder_ack, 1'b0);
    check_eq("drop_rdy", {bus.write_rdy1, bus.write_rdy2, bus.write_rdy3}, 3'b111);
    check_eq("keep_out", bus.adder_outputs, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a, b;
    logic [W-1:0] cfg;

    idle_inputs();
    bus.w_data_in1 = '0; bus.w_data_in2 = '0; bus.w_data_in3 = '0;

    // Reset and idle
    reset = 1'b1;
    tick(); tick();
    check_eq("rst_rdy", {bus.write_rdy1, bus.write_rdy2, bus.write_rdy3}, 3'b000);
    check_eq("rst_ack", {bus.write_ack1, bus.write_ack2, bus.write_ack3, bus.adder_ack}, 4'h0);
    reset = 1'b0;
    tick();
    check_eq("idle_rdy", {bus.write_rdy1, bus.write_rdy2, bus.write_rdy3}, 3'b111);
    check_eq("idle_ack", bus.adder_ack, 1'b0);
    check_eq("idle_out", bus.adder_outputs, 64'h0);
    check_eq("idle_dest", bus.dest_info, 4'h0);

    // Pairwise reduce
    a = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    b = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    load_parallel(16'h0001, a, b);
    finish_op(16'h0001, a, b, 1'b0);
`ifdef VTILE_SAT_ARITH_EN
    check_eq("reduce_const", bus.adder_outputs, 64'h0000_0001_FFFF_FFFF);
`else
    check_eq("reduce_const", bus.adder_outputs, 64'h0000_0001_FFFF_FFFE);
`endif

    // Elementwise add with dest tag
    a = '{1, 2, 3, 4};
    b = '{16'h10, 16'h20, 16'h30, 16'h40};
    load_parallel(16'h0A00, a, b);
    bus.on_off = 1'b1;
    tick(); tick();
    check_eq("add_const", bus.adder_outputs, 64'h0044_0033_0022_0011);
    check_eq("add_dest", bus.dest_info, 4'hA);
    bus.on_off = 1'b0;
    tick();

    // Subtract
    a = '{0, 5, 7, 9};
    b = '{1, 3, 2, 9};
    load_parallel(16'h0002, a, b);
    finish_op(16'h0002, a, b, 1'b0);
`ifdef VTILE_SAT_ARITH_EN
    check_eq("sub_const", bus.adder_outputs, 64'h0000_0005_0002_0000);
`else
    check_eq("sub_const", bus.adder_outputs, 64'h0000_0005_0002_FFFF);
`endif

    // write_en3 held high after its ack
    a = '{16'h1234, 16'h00FF, 16'h8000, 16'h7FFF};
    b = '{16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0001};
    bus.w_data_in1 = pack(a); bus.w_data_in2 = pack(b); bus.w_data_in3 = 16'h0303;
    bus.write_en1 = 1'b1; bus.write_en2 = 1'b1; bus.write_en3 = 1'b1;
    tick();
    check_eq("hs_ack3", bus.write_ack3, 1'b1);
    bus.write_en1 = 1'b0; bus.write_en2 = 1'b0;
    bus.on_off = 1'b1;
    tick();
    check_eq("hs_no_ack3", bus.write_ack3, 1'b0);
    check_eq("hs_rdy3_exec", bus.write_rdy3, 1'b0);
    tick();
    check_eq("hs_and", bus.adder_outputs, ref_result(3, a, b));
    check_eq("hs_rdy3_done", {bus.write_rdy3, bus.write_ack3}, 2'b00);
    bus.on_off = 1'b0;
    tick();
    check_eq("hs_rdy3_back", bus.write_rdy3, 1'b1);
    bus.write_en3 = 1'b0;
    tick();

    // on_off while vector 2 is still empty
    a = '{10, 20, 30, 40};
    b = '{5, 6, 7, 8};
    bus.w_data_in1 = pack(a); bus.w_data_in2 = pack(b); bus.w_data_in3 = 16'h0500;
    bus.write_en1 = 1'b1; bus.write_en3 = 1'b1;
    tick();
    bus.write_en1 = 1'b0; bus.write_en3 = 1'b0;
    bus.on_off = 1'b1;
    repeat (4) tick();
    check_eq("wait_ack", bus.adder_ack, 1'b0);
    check_eq("wait_rdy2", {bus.write_rdy1, bus.write_rdy2, bus.write_rdy3}, 3'b010);
    bus.write_en2 = 1'b1;
    tick();
    check_eq("wait_ack2", bus.write_ack2, 1'b1);
    bus.write_en2 = 1'b0;
    tick();
    check_eq("wait_lat1", bus.adder_ack, 1'b0);
    tick();
    check_eq("wait_lat2", bus.adder_ack, 1'b1);
    check_eq("wait_out", bus.adder_outputs, ref_result(0, a, b));
    check_eq("wait_dest", bus.dest_info, 4'h5);
    bus.on_off = 1'b0;
    tick();

    // Reset asserted during EXEC
    load_parallel(16'h0F00, a, b);
    bus.on_off = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_eq("rexec_ack", bus.adder_ack, 1'b0);
    check_eq("rexec_out", bus.adder_outputs, 64'h0);
    check_eq("rexec_dest", bus.dest_info, 4'h0);
    reset = 1'b0;
    bus.on_off = 1'b0;
    tick();
    check_eq("rexec_ack2", bus.adder_ack, 1'b0);
    check_eq("rexec_rdy", {bus.write_rdy1, bus.write_rdy2, bus.write_rdy3}, 3'b111);

    // Randomized operations
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < N; k++) begin a[k] = rand_word(); b[k] = rand_word(); end
      cfg = W'($urandom_range(0, 32'(MAXV)));
      load_random(cfg, a, b, bit'($urandom_range(0, 1)));
      finish_op(cfg, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
